// File: rtl/iir_pkg.sv
// Shared definitions for the lookahead IIR coefficient path: data width,
// configuration addresses, controller states and the product count.
package iir_pkg;

   localparam int NB    = 12;
   localparam int N_PRD = 5;

   localparam logic [2:0] ADDR_A1 = 3'd0;
   localparam logic [2:0] ADDR_A2 = 3'd1;
   localparam logic [2:0] ADDR_B0 = 3'd2;
   localparam logic [2:0] ADDR_B1 = 3'd3;
   localparam logic [2:0] ADDR_B2 = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MUL    = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/iir_coef_ctrl_mul.sv
// Registered signed Q1.(NB-1) multiply: floor shift back to NB bits,
// saturating the single overflow case (-1 * -1).
import iir_pkg::*;

module coef_mul (
   input  logic          CLK,
   input  logic          RST_n,
   input  logic [NB-1:0] i_x,
   input  logic [NB-1:0] i_y,
   output logic [NB-1:0] o_p
);

   logic signed [2*NB-1:0] w_xe;
   logic signed [2*NB-1:0] w_ye;
   logic signed [2*NB-1:0] w_p;
   logic        [NB-1:0]   w_res;
   logic        [NB-1:0]   r_p;

   assign w_xe = {{NB{i_x[NB-1]}}, i_x};
   assign w_ye = {{NB{i_y[NB-1]}}, i_y};
   assign w_p  = w_xe * w_ye;

   // Top two bits of the shifted product disagree only when the result exceeds NB bits
   always_comb begin
      w_res = w_p[2*NB-2:NB-1];
      if (w_p[2*NB-1] != w_p[2*NB-2]) begin
         w_res = w_p[2*NB-1] ? {1'b1, {(NB-1){1'b0}}} : {1'b0, {(NB-1){1'b1}}};
      end else begin
         w_res = w_p[2*NB-2:NB-1];
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_p <= {NB{1'b0}};
      end else begin
         r_p <= w_res;
      end
   end

   assign o_p = r_p;

endmodule

// File: rtl/iir_coef_ctrl.sv
// Coefficient controller: shadow writes, time-multiplexed lookahead products,
// single-edge swap of the active set, and input-valid gating.
import iir_pkg::*;

module iir_coef_ctrl (
   input  logic          CLK,
   input  logic          RST_n,
   input  logic          CFG_WE,
   input  logic [2:0]    CFG_ADDR,
   input  logic [NB-1:0] CFG_DATA,
   input  logic          CFG_START,
   output logic          CFG_BUSY,
   output logic          CFG_DONE,
   input  logic          VIN_UP,
   output logic          VIN,
   output logic          COEF_VALID,
   output logic [NB-1:0] A1,
   output logic [NB-1:0] A2,
   output logic [NB-1:0] B0,
   output logic [NB-1:0] B1,
   output logic [NB-1:0] B2,
   output logic [NB-1:0] A0A1,
   output logic [NB-1:0] A1A1,
   output logic [NB-1:0] A1A2,
   output logic [NB-1:0] A1B0,
   output logic [NB-1:0] A1B1,
   output logic [NB-1:0] A1B2
);

   state_t        r_state;
   logic [2:0]    r_idx;
   logic [1:0]    r_cap_idx;
   logic          r_cap_vld;
   logic          r_busy;
   logic          r_done;
   logic          r_valid;
   logic [NB-1:0] r_sh     [N_PRD];
   logic [NB-1:0] r_prd_sh [N_PRD-1];
   logic [NB-1:0] r_act    [N_PRD];
   logic [NB-1:0] r_act_p  [N_PRD+1];
   logic [NB-1:0] w_y;
   logic [NB-1:0] w_mul_q;

   always_comb begin
      w_y = {NB{1'b0}};
      case (r_idx)
         3'd0:    w_y = r_sh[0];
         3'd1:    w_y = r_sh[1];
         3'd2:    w_y = r_sh[2];
         3'd3:    w_y = r_sh[3];
         3'd4:    w_y = r_sh[4];
         default: w_y = {NB{1'b0}};
      endcase
   end

   coef_mul u_mul (
      .CLK   (CLK),
      .RST_n (RST_n),
      .i_x   (r_sh[ADDR_A1]),
      .i_y   (w_y),
      .o_p   (w_mul_q)
   );

   // Multiplier output lags the index by one cycle; the last product goes straight to the active set
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_state   <= ST_IDLE;
         r_idx     <= 3'd0;
         r_cap_idx <= 2'd0;
         r_cap_vld <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_valid   <= 1'b0;
         for (int i = 0; i < N_PRD; i++) begin
            r_sh[i]  <= {NB{1'b0}};
            r_act[i] <= {NB{1'b0}};
         end
         for (int i = 0; i < N_PRD - 1; i++) r_prd_sh[i] <= {NB{1'b0}};
         for (int i = 0; i < N_PRD + 1; i++) r_act_p[i]  <= {NB{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done    <= 1'b0;
               r_cap_vld <= 1'b0;
               if (CFG_WE && (CFG_ADDR < 3'(N_PRD))) begin
                  r_sh[CFG_ADDR] <= CFG_DATA;
               end
               if (CFG_START) begin
                  r_state <= ST_MUL;
                  r_idx   <= 3'd0;
                  r_busy  <= 1'b1;
               end
            end
            ST_MUL: begin
               r_cap_idx <= r_idx[1:0];
               r_cap_vld <= 1'b1;
               if (r_cap_vld) begin
                  r_prd_sh[r_cap_idx] <= w_mul_q;
               end
               if (r_idx == 3'(N_PRD - 1)) begin
                  r_state <= ST_COMMIT;
               end else begin
                  r_idx <= r_idx + 3'd1;
               end
            end
            ST_COMMIT: begin
               for (int i = 0; i < N_PRD; i++) r_act[i] <= r_sh[i];
               r_act_p[0] <= r_sh[ADDR_A1];
               for (int i = 0; i < N_PRD - 1; i++) r_act_p[i+1] <= r_prd_sh[i];
               r_act_p[N_PRD] <= w_mul_q;
               r_cap_vld <= 1'b0;
               r_busy    <= 1'b0;
               r_done    <= 1'b1;
               r_valid   <= 1'b1;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_busy    <= 1'b0;
               r_done    <= 1'b0;
               r_cap_vld <= 1'b0;
            end
         endcase
      end
   end

   assign CFG_BUSY   = r_busy;
   assign CFG_DONE   = r_done;
   assign COEF_VALID = r_valid;
   assign VIN        = VIN_UP & r_valid;
   assign A1   = r_act[ADDR_A1];
   assign A2   = r_act[ADDR_A2];
   assign B0   = r_act[ADDR_B0];
   assign B1   = r_act[ADDR_B1];
   assign B2   = r_act[ADDR_B2];
   assign A0A1 = r_act_p[0];
   assign A1A1 = r_act_p[1];
   assign A1A2 = r_act_p[2];
   assign A1B0 = r_act_p[3];
   assign A1B1 = r_act_p[4];
   assign A1B2 = r_act_p[5];

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Directed bench for iir_coef_ctrl: hand-computed products, commit timing,
// busy-time ignores, same-cycle write+start and mid-commit reset.
module tb_iir_coef_ctrl;
   import iir_pkg::*;

   logic          CLK = 1'b0;
   logic          RST_n = 1'b0;
   logic          CFG_WE = 1'b0;
   logic [2:0]    CFG_ADDR = 3'd0;
   logic [NB-1:0] CFG_DATA = 12'h000;
   logic          CFG_START = 1'b0;
   logic          CFG_BUSY, CFG_DONE, VIN, COEF_VALID;
   logic          VIN_UP = 1'b0;
   logic [NB-1:0] A1, A2, B0, B1, B2, A0A1, A1A1, A1A2, A1B0, A1B1, A1B2;

   int n_tests = 0;
   int n_fail  = 0;

   iir_coef_ctrl dut (
      .CLK(CLK), .RST_n(RST_n), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
      .CFG_DATA(CFG_DATA), .CFG_START(CFG_START), .CFG_BUSY(CFG_BUSY),
      .CFG_DONE(CFG_DONE), .VIN_UP(VIN_UP), .VIN(VIN), .COEF_VALID(COEF_VALID),
      .A1(A1), .A2(A2), .B0(B0), .B1(B1), .B2(B2), .A0A1(A0A1), .A1A1(A1A1),
      .A1A2(A1A2), .A1B0(A1B0), .A1B1(A1B1), .A1B2(A1B2)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] prods();
      return {A0A1, A1A1, A1A2, A1B0, A1B1, A1B2};
   endfunction

   function automatic logic [59:0] coefs();
      return {A1, A2, B0, B1, B2};
   endfunction

   task automatic wr(input logic [2:0] a, input logic [NB-1:0] d);
      CFG_WE = 1'b1; CFG_ADDR = a; CFG_DATA = d;
      @(negedge CLK);
      CFG_WE = 1'b0;
   endtask

   // Issue START (optionally with a write), then check exact busy/done timing and final outputs
   task automatic commit(input string tag, input logic we, input logic [2:0] a,
                         input logic [NB-1:0] d, input logic [71:0] exp_p,
                         input logic [59:0] exp_c, input logic busy_poke);
      logic [71:0] old_p;
      old_p = prods();
      CFG_WE = we; CFG_ADDR = a; CFG_DATA = d; CFG_START = 1'b1;
      @(negedge CLK);
      CFG_WE = 1'b0; CFG_START = 1'b0;
      chk({tag, "_busy_k"}, 128'(CFG_BUSY), 128'(1'b1));
      for (int i = 1; i <= 5; i++) begin
         if (busy_poke && i == 2) begin
            CFG_WE = 1'b1; CFG_ADDR = ADDR_A1; CFG_DATA = 12'h123; CFG_START = 1'b1;
         end else begin
            CFG_WE = 1'b0; CFG_START = 1'b0;
         end
         @(negedge CLK);
         chk({tag, "_nodone"}, 128'({CFG_DONE, CFG_BUSY}), 128'(2'b01));
      end
      CFG_WE = 1'b0; CFG_START = 1'b0;
      chk({tag, "_hold"}, 128'(prods()), 128'(old_p));
      @(negedge CLK);
      chk({tag, "_done"}, 128'({CFG_DONE, CFG_BUSY, COEF_VALID}), 128'(3'b101));
      chk({tag, "_prods"}, 128'(prods()), 128'(exp_p));
      chk({tag, "_coefs"}, 128'(coefs()), 128'(exp_c));
      @(negedge CLK);
      chk({tag, "_done_end"}, 128'({CFG_DONE, CFG_BUSY}), 128'(2'b00));
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      RST_n = 1'b1;
      VIN_UP = 1'b1;
      @(negedge CLK);
      chk("rst_vin", 128'({VIN, COEF_VALID, CFG_BUSY, CFG_DONE}), 128'(4'b0000));
      chk("rst_prods", 128'(prods()), 128'(72'h0));
      chk("rst_coefs", 128'(coefs()), 128'(60'h0));

      wr(ADDR_A1, 12'h200); wr(ADDR_A2, 12'h400); wr(ADDR_B0, 12'hC00);
      wr(ADDR_B1, 12'h7FF); wr(ADDR_B2, 12'h800);
      wr(3'd6, 12'h555);
      chk("shadow_not_active", 128'(coefs()), 128'(60'h0));
      commit("set1", 1'b0, 3'd0, 12'h000,
             {12'h200, 12'h080, 12'h100, 12'hF00, 12'h1FF, 12'hE00},
             {12'h200, 12'h400, 12'hC00, 12'h7FF, 12'h800}, 1'b0);
      chk("vin_pass", 128'(VIN), 128'(1'b1));
      VIN_UP = 1'b0;
      #1 chk("vin_low", 128'(VIN), 128'(1'b0));
      VIN_UP = 1'b1;

      wr(ADDR_A1, 12'h800);
      commit("sat", 1'b0, 3'd0, 12'h000,
             {12'h800, 12'h7FF, 12'hC00, 12'h400, 12'h801, 12'h7FF},
             {12'h800, 12'h400, 12'hC00, 12'h7FF, 12'h800}, 1'b1);
      commit("after_poke", 1'b0, 3'd0, 12'h000,
             {12'h800, 12'h7FF, 12'hC00, 12'h400, 12'h801, 12'h7FF},
             {12'h800, 12'h400, 12'hC00, 12'h7FF, 12'h800}, 1'b0);
      commit("same_cyc", 1'b1, ADDR_A1, 12'h400,
             {12'h400, 12'h200, 12'h200, 12'hE00, 12'h3FF, 12'hC00},
             {12'h400, 12'h400, 12'hC00, 12'h7FF, 12'h800}, 1'b0);

      CFG_START = 1'b1;
      @(negedge CLK);
      CFG_START = 1'b0;
      repeat (2) @(negedge CLK);
      RST_n = 1'b0;
      #1;
      chk("mid_rst_prods", 128'(prods()), 128'(72'h0));
      chk("mid_rst_coefs", 128'(coefs()), 128'(60'h0));
      chk("mid_rst_flags", 128'({CFG_BUSY, CFG_DONE, COEF_VALID, VIN}), 128'(4'b0000));
      @(negedge CLK);
      RST_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         chk("post_rst_quiet", 128'({CFG_DONE, CFG_BUSY, VIN}), 128'(3'b000));
      end
      chk("post_rst_prods", 128'(prods()), 128'(72'h0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/iir_coef_ctrl.md
# iir_coef_ctrl

Coefficient controller for the 12-bit lookahead IIR filter (`iir_lookahead`). It accepts coefficient writes from a configuration port into shadow registers. On a commit request it computes the six lookahead products (A0A1, A1A1, A1A2, A1B0, A1B1, A1B2) using one shared, time-multiplexed multiplier, then swaps all eleven coefficient outputs into the filter in a single cycle. It also gates the filter's input-valid strobe until a coefficient set is committed.

## Interface
- `NB`, 12, coefficient/data width; signed Q1.(NB-1)
- `CLK`  in  1  clock, rising edge
- `RST_n`  in  1  reset, asynchronous, active-low
- `CFG_WE`  in  1  shadow write strobe
- `CFG_ADDR`  in  3  0=A1, 1=A2, 2=B0, 3=B1, 4=B2; 5..7 ignored
- `CFG_DATA`  in  NB  value to write
- `CFG_START`  in  1  commit request (one-cycle level sample)
- `CFG_BUSY`  out  1  controller computing/committing
- `CFG_DONE`  out  1  one-cycle pulse, new set active
- `VIN_UP`  in  1  sample valid from upstream source
- `VIN`  out  1  valid to filter = VIN_UP & COEF_VALID (combinational)
- `COEF_VALID`  out  1  active set has been committed at least once since reset
- `A1`,`A2`,`B0`,`B1`,`B2`  out  NB each  active coefficients
- `A0A1`,`A1A1`,`A1A2`,`A1B0`,`A1B1`,`A1B2`  out  NB each  active lookahead products

## Operation
- States: IDLE, MUL, COMMIT.
- IDLE:
  - `CFG_WE`=1 writes `CFG_DATA` to shadow[`CFG_ADDR`].
  - `CFG_START`=1 goes to MUL with index 0.
- MUL:
  - Index 0..4 selects shadow pairs (A1,A1), (A1,A2), (A1,B0), (A1,B1), (A1,B2).
  - One product is registered per cycle into a product shadow.
  - After index 4, go to COMMIT.
- COMMIT:
  - Copy the shadow coefficients and product shadow to the active outputs in one edge.
  - A0A1 takes shadow A1 (a0 = 1).
  - Set `COEF_VALID`=1, pulse `CFG_DONE`, return to IDLE.
- Arithmetic:
  - p = X*Y as a 2·NB signed product; result = p >>> (NB-1) (floor, arithmetic).
  - Saturate to [0x800, 0x7FF] if the result does not fit NB bits. The only overflow case is -1·-1, which gives 0x7FF.
- `CFG_WE` or `CFG_START` while BUSY: ignored, no state change, no error.
- `CFG_WE` and `CFG_START` in the same IDLE cycle: the write lands first; the computation uses the updated shadow.
- Active outputs never change except at the COMMIT edge, so the filter never sees a mixed set.
- Reset (any time, including mid-MUL):
  - All shadow, product and active registers = 0.
  - `COEF_VALID`=0, `CFG_BUSY`=0, `CFG_DONE`=0, state IDLE.
  - Any commit in progress is discarded.

## Timing
- `CFG_START` sampled high at edge k:
  - state = MUL from k.
  - Products are registered at edges k+1..k+5.
  - COMMIT occupies the cycle after k+5.
  - Active outputs update at edge k+6.
  - `CFG_DONE` is high for exactly the cycle k+6..k+7.
- `CFG_BUSY`: high from edge k until edge k+6; low in the `CFG_DONE` cycle.
- Back-to-back: a new `CFG_START` is accepted at edge k+7 at the earliest.
- `VIN`: zero latency from `VIN_UP`; forced 0 while `COEF_VALID`=0. It is not gated by BUSY, so the filter keeps running on the old set during a recompute.

## Structure
- Shared package `iir_pkg`:
  - `NB`
  - CFG_ADDR constants (ADDR_A1..ADDR_B2)
  - FSM state enum
  - product-index count (5)
- One natural sub-module: `coef_mul`. It is a registered signed NB×NB multiply with shift-floor and saturation; the controller instantiates it once.

## Test plan
- Reset, then `VIN_UP`=1 with no commit → `VIN`=0, `COEF_VALID`=0, all coefficient outputs 0.
- Write A1=0x200, A2=0x400, B0=0xC00, B1=0x7FF, B2=0x800, then START → `CFG_DONE` at k+6, with A0A1=0x200, A1A1=0x080, A1A2=0x100, A1B0=0xF00, A1B1=0x1FF, A1B2=0xE00.
- A1=0x800, START → A1A1=0x7FF (saturated), A1B2 computed against the current B2.
- During BUSY, write A1=0x123 and pulse START → both ignored. Outputs equal the pre-BUSY shadow result; one `CFG_DONE` only; next commit still uses the old A1.
- Same-cycle `CFG_WE`(A1=0x400) + START in IDLE → A1A1=0x200.
- Assert `RST_n`=0 at k+3 of a commit → all outputs 0 immediately; no `CFG_DONE`; `VIN`=0 after release.
